// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key-event source.
package ps2_pkg;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int KEY_CODE_LSB = 0;
  localparam int KEY_EXT      = 8;
  localparam int KEY_PRESSED  = 9;
  localparam int KEY_TOGGLE   = 10;

  // Bytes following E1 that belong to the Pause make sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_st_e;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } byte_s;
endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus FILTER-sample glitch filter for one PS/2 line,
// with an optional one-cycle pulse on each filtered falling edge.
module ps2_line_filter #(
  parameter int FILTER  = 8,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall
);
  localparam int CW = $clog2(FILTER + 1);

  logic          r_s1, r_s2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_fall;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_fall <= 1'b0;
      // Any sample agreeing with the current level restarts the count.
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER - 1)) begin
        r_level <= r_s2;
        r_cnt   <= '0;
        r_fall  <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = EDGE_EN & r_fall;
endmodule

// File: rtl/ps2_key_source.sv
// PS/2 keyboard receiver: frames bytes off the serial line and assembles
// E0/F0/E1 prefixes into an 11-bit toggle-flagged key-event word.
module ps2_key_source
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 12000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);
  localparam int TW = $clog2(TIMEOUT);

  logic w_clk_level, w_clk_fall;
  logic w_data, w_unused_data_fall;

  ps2_line_filter #(.FILTER(FILTER), .EDGE_EN(1'b1)) u_clk_filt (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_raw   (ps2_clk),
    .o_level (w_clk_level),
    .o_fall  (w_clk_fall)
  );

  ps2_line_filter #(.FILTER(FILTER), .EDGE_EN(1'b0)) u_data_filt (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_raw   (ps2_data),
    .o_level (w_data),
    .o_fall  (w_unused_data_fall)
  );

  frame_st_e       r_state, w_state_nx;
  logic [7:0]      r_shift, w_shift_nx;
  logic [2:0]      r_bitcnt, w_bitcnt_nx;
  logic            r_par, w_par_nx;
  logic [TW-1:0]   r_tcnt, w_tcnt_nx;
  logic            r_err, w_err_nx;
  byte_s           r_byte, w_byte_nx;

  logic            r_ext, r_rel;
  logic [2:0]      r_skip;
  logic [10:0]     r_key;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_tcnt   <= '0;
      r_err    <= 1'b0;
      r_byte   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_shift  <= w_shift_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_par    <= w_par_nx;
      r_tcnt   <= w_tcnt_nx;
      r_err    <= w_err_nx;
      r_byte   <= w_byte_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_shift_nx  = r_shift;
    w_bitcnt_nx = r_bitcnt;
    w_par_nx    = r_par;
    w_err_nx    = 1'b0;
    w_byte_nx   = '{vld: 1'b0, data: r_shift};
    w_tcnt_nx   = (r_state == ST_IDLE || w_clk_fall) ? '0 : r_tcnt + 1'b1;

    // An accepted edge takes priority over a coincident timeout.
    if (w_clk_fall) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_data) begin
            w_state_nx  = ST_DATA;
            w_bitcnt_nx = '0;
          end
        end
        ST_DATA: begin
          w_shift_nx  = {w_data, r_shift[7:1]};
          w_bitcnt_nx = r_bitcnt + 1'b1;
          if (r_bitcnt == 3'd7) w_state_nx = ST_PARITY;
        end
        ST_PARITY: begin
          w_par_nx   = w_data;
          w_state_nx = ST_STOP;
        end
        ST_STOP: begin
          w_state_nx = ST_IDLE;
          if (w_data && (^{r_shift, r_par})) w_byte_nx.vld = 1'b1;
          else                               w_err_nx      = 1'b1;
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && r_tcnt == TW'(TIMEOUT - 1)) begin
      w_state_nx = ST_IDLE;
      w_err_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_ext  <= 1'b0;
      r_rel  <= 1'b0;
      r_skip <= '0;
      r_key  <= '0;
    end else if (r_byte.vld) begin
      if (r_skip != '0) begin
        r_skip <= r_skip - 1'b1;
      end else if (r_byte.data == PS2_EXT) begin
        r_ext <= 1'b1;
      end else if (r_byte.data == PS2_BRK) begin
        r_rel <= 1'b1;
      end else if (r_byte.data == PS2_PAUSE) begin
        r_skip <= PAUSE_SKIP;
      end else begin
        r_key[KEY_CODE_LSB +: 8] <= r_byte.data;
        r_key[KEY_EXT]           <= r_ext;
        r_key[KEY_PRESSED]       <= ~r_rel;
        r_key[KEY_TOGGLE]        <= ~r_key[KEY_TOGGLE];
        r_ext                    <= 1'b0;
        r_rel                    <= 1'b0;
      end
    end
  end

  assign ps2_key   = r_key;
  assign frame_err = r_err;
endmodule
